// File: rtl/adc_data_pkg.sv
// Shared lane-state type, counter width and sign-extension helper for the
// ADC lane alignment / sample assembly path.
package adc_data_pkg;

    localparam int unsigned CNT_W = 4;
    localparam int unsigned SX_W  = 64;

    typedef enum logic [2:0] {
        LANE_IDLE   = 3'd0,
        LANE_CHECK  = 3'd1,
        LANE_SLIP   = 3'd2,
        LANE_SETTLE = 3'd3,
        LANE_LOCKED = 3'd4,
        LANE_FAIL   = 3'd5
    } laneState_e;

    // Replicate bit sampleW-1 upward to outW bits; bits at and above outW are zero.
    function automatic logic [SX_W-1:0] sign_ext(
        input logic [SX_W-1:0] sample,
        input int unsigned     sampleW,
        input int unsigned     outW
    );
        logic [SX_W-1:0] aligned;
        logic [SX_W-1:0] keep;
        aligned = sample << (SX_W - sampleW);
        keep    = ~({SX_W{1'b1}} << outW);
        return SX_W'($signed(aligned) >>> (SX_W - sampleW)) & keep;
    endfunction

endpackage

// File: rtl/adc_lane_slip.sv
// Training-pattern alignment FSM for one serial lane: compares the lane word
// against its training slice and pulses bitslip until MATCH_CNT hits in a row.
module adc_lane_slip
    import adc_data_pkg::*;
#(
    parameter int unsigned SER_W     = 7,
    parameter int unsigned SETTLE    = 4,
    parameter int unsigned MATCH_CNT = 4,
    parameter int unsigned MAX_SLIP  = 7
) (
    input  logic             DatClkDiv,
    input  logic             DatRstN,
    input  logic             FrmAlignDone,
    input  logic             AlignStart,
    input  logic [SER_W-1:0] LaneWord,
    input  logic [SER_W-1:0] TrainWord,
    output logic             Bitslip,
    output logic             Locked,
    output logic             AlignErr
);

    localparam logic [CNT_W-1:0] MATCH_LAST  = CNT_W'(MATCH_CNT);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] SLIP_LAST   = CNT_W'(MAX_SLIP);

    laneState_e       state;
    laneState_e       stateNext;
    logic [CNT_W-1:0] matchCnt;
    logic [CNT_W-1:0] matchCntNext;
    logic [CNT_W-1:0] slipCnt;
    logic [CNT_W-1:0] slipCntNext;
    logic [CNT_W-1:0] settleCnt;
    logic [CNT_W-1:0] settleCntNext;
    logic             bitslipNext;
    logic             lockedNext;
    logic             errNext;

    // Next-state and counter logic; frame loss dominates a restart request.
    always_comb begin
        stateNext     = state;
        matchCntNext  = matchCnt;
        slipCntNext   = slipCnt;
        settleCntNext = settleCnt;
        errNext       = AlignErr;

        if (!FrmAlignDone) begin
            stateNext = LANE_IDLE;
        end else if (AlignStart) begin
            stateNext    = LANE_CHECK;
            matchCntNext = '0;
            slipCntNext  = '0;
            errNext      = 1'b0;
        end else begin
            case (state)
                LANE_IDLE: begin
                    stateNext = LANE_IDLE;
                end
                LANE_CHECK: begin
                    if (LaneWord == TrainWord) begin
                        matchCntNext = matchCnt + CNT_W'(1);
                        if (matchCntNext == MATCH_LAST) begin
                            stateNext = LANE_LOCKED;
                        end
                    end else begin
                        matchCntNext = '0;
                        if (slipCnt == SLIP_LAST) begin
                            stateNext = LANE_FAIL;
                            errNext   = 1'b1;
                        end else begin
                            stateNext = LANE_SLIP;
                        end
                    end
                end
                LANE_SLIP: begin
                    slipCntNext   = slipCnt + CNT_W'(1);
                    settleCntNext = '0;
                    stateNext     = LANE_SETTLE;
                end
                LANE_SETTLE: begin
                    if (settleCnt == SETTLE_LAST) begin
                        stateNext = LANE_CHECK;
                    end else begin
                        settleCntNext = settleCnt + CNT_W'(1);
                    end
                end
                LANE_LOCKED: begin
                    stateNext = LANE_LOCKED;
                end
                LANE_FAIL: begin
                    stateNext = LANE_FAIL;
                end
                default: begin
                    stateNext = LANE_IDLE;
                end
            endcase
        end

        bitslipNext = (stateNext == LANE_SLIP);
        lockedNext  = (stateNext == LANE_LOCKED);
    end

    always_ff @(posedge DatClkDiv or negedge DatRstN) begin
        if (!DatRstN) begin
            state     <= LANE_IDLE;
            matchCnt  <= '0;
            slipCnt   <= '0;
            settleCnt <= '0;
            Bitslip   <= 1'b0;
            Locked    <= 1'b0;
            AlignErr  <= 1'b0;
        end else begin
            state     <= stateNext;
            matchCnt  <= matchCntNext;
            slipCnt   <= slipCntNext;
            settleCnt <= settleCntNext;
            Bitslip   <= bitslipNext;
            Locked    <= lockedNext;
            AlignErr  <= errNext;
        end
    end

endmodule

// File: rtl/adc_data_align.sv
// Multi-lane ADC capture: per-lane bitslip alignment, then per-channel sample
// assembly with sign extension. Define ADC_DATA_BITREV_EN for LSB-first serdes.
module adc_data_align
    import adc_data_pkg::*;
#(
    parameter int unsigned            NUM_CH    = 2,
    parameter int unsigned            LANES     = 2,
    parameter int unsigned            SER_W     = 7,
    parameter int unsigned            OUT_W     = 16,
    parameter logic [LANES*SER_W-1:0] TRAIN_PAT = 14'h2A55,
    parameter int unsigned            SETTLE    = 4,
    parameter int unsigned            MATCH_CNT = 4,
    parameter int unsigned            MAX_SLIP  = SER_W
) (
    input  logic                          DatClkDiv,
    input  logic                          DatRstN,
    input  logic                          FrmAlignDone,
    input  logic                          AlignStart,
    input  logic [NUM_CH*LANES*SER_W-1:0] SerData,
    output logic [NUM_CH*LANES-1:0]       DatBitslip,
    output logic [NUM_CH*OUT_W-1:0]       DatData,
    output logic                          DatValid,
    output logic                          DatAlignDone,
    output logic [NUM_CH*LANES-1:0]       DatAlignErr
);

    localparam int unsigned SAMPLE_W  = LANES * SER_W;
    localparam int unsigned NUM_LANES = NUM_CH * LANES;

    logic [NUM_LANES*SER_W-1:0] laneWords;
    logic [NUM_LANES-1:0]       laneLocked;
    logic [NUM_CH*OUT_W-1:0]    datDataNext;
    logic                       alignDoneNext;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        localparam int unsigned L = i % LANES;

`ifdef ADC_DATA_BITREV_EN
        for (genvar b = 0; b < SER_W; b++) begin : g_rev
            assign laneWords[i*SER_W + b] = SerData[i*SER_W + SER_W - 1 - b];
        end
`else
        assign laneWords[i*SER_W +: SER_W] = SerData[i*SER_W +: SER_W];
`endif

        adc_lane_slip #(
            .SER_W     (SER_W),
            .SETTLE    (SETTLE),
            .MATCH_CNT (MATCH_CNT),
            .MAX_SLIP  (MAX_SLIP)
        ) u_lane (
            .DatClkDiv    (DatClkDiv),
            .DatRstN      (DatRstN),
            .FrmAlignDone (FrmAlignDone),
            .AlignStart   (AlignStart),
            .LaneWord     (laneWords[i*SER_W +: SER_W]),
            .TrainWord    (TRAIN_PAT[L*SER_W +: SER_W]),
            .Bitslip      (DatBitslip[i]),
            .Locked       (laneLocked[i]),
            .AlignErr     (DatAlignErr[i])
        );
    end

    // A channel's lanes are contiguous, so its sample is one slice with lane 0 lowest.
    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        logic [SX_W-1:0] extSample;
        assign extSample = sign_ext(SX_W'(laneWords[ch*SAMPLE_W +: SAMPLE_W]), SAMPLE_W, OUT_W);
        assign datDataNext[ch*OUT_W +: OUT_W] = extSample[OUT_W-1:0];
    end

    // Lane lock flags are registered, so a restart must be masked here to drop done promptly.
    assign alignDoneNext = FrmAlignDone && !AlignStart && (&laneLocked);

    always_ff @(posedge DatClkDiv or negedge DatRstN) begin
        if (!DatRstN) begin
            DatData      <= '0;
            DatValid     <= 1'b0;
            DatAlignDone <= 1'b0;
        end else begin
            DatData      <= datDataNext;
            DatValid     <= alignDoneNext;
            DatAlignDone <= alignDoneNext;
        end
    end

endmodule

// File: tb/tb_adc_data_align.sv
// Directed bench for adc_data_align with a rotating-word serdes model per lane.
module tb_adc_data_align;

    localparam int NL = 4;

    logic            DatClkDiv = 1'b0;
    logic            DatRstN;
    logic            FrmAlignDone;
    logic            AlignStart;
    logic [NL*7-1:0] SerData;
    logic [NL-1:0]   DatBitslip;
    logic [31:0]     DatData;
    logic            DatValid;
    logic            DatAlignDone;
    logic [NL-1:0]   DatAlignErr;

    int errors = 0;
    int checks = 0;
    int tickNum = 0;
    logic modelOn;
    logic [6:0] base [NL];
    int offs [NL];
    int pulseCnt [NL];
    int pulseTick [NL][16];

    adc_data_align dut (
        .DatClkDiv    (DatClkDiv),
        .DatRstN      (DatRstN),
        .FrmAlignDone (FrmAlignDone),
        .AlignStart   (AlignStart),
        .SerData      (SerData),
        .DatBitslip   (DatBitslip),
        .DatData      (DatData),
        .DatValid     (DatValid),
        .DatAlignDone (DatAlignDone),
        .DatAlignErr  (DatAlignErr)
    );

    always #5 DatClkDiv = ~DatClkDiv;

    function automatic logic [6:0] rotl7(input logic [6:0] w, input int n);
        logic [6:0] r;
        r = w;
        for (int k = 0; k < n; k++) r = {r[5:0], r[6]};
        return r;
    endfunction

    function automatic logic [6:0] toWire(input logic [6:0] w);
`ifdef ADC_DATA_BITREV_EN
        logic [6:0] r;
        r = {<<{w}};
        return r;
`else
        return w;
`endif
    endfunction

    function automatic logic [6:0] patOf(input int i);
        return (i % 2 == 0) ? 7'h55 : 7'h54;
    endfunction

    task automatic driveModel();
        for (int i = 0; i < NL; i++) SerData[i*7 +: 7] = rotl7(toWire(base[i]), offs[i]);
    endtask

    task automatic setAligned();
        modelOn = 1'b1;
        for (int i = 0; i < NL; i++) begin
            base[i] = patOf(i);
            offs[i] = 0;
        end
        driveModel();
    endtask

    // One clock: returns at the negedge after a posedge; models bitslip as a 1-bit rotation.
    task automatic tick();
        @(negedge DatClkDiv);
        tickNum++;
        for (int i = 0; i < NL; i++) begin
            if (DatBitslip[i] === 1'b1) begin
                if (pulseCnt[i] < 16) pulseTick[i][pulseCnt[i]] = tickNum;
                pulseCnt[i]++;
                offs[i] = (offs[i] + 1) % 7;
            end
        end
        if (modelOn) driveModel();
    endtask

    task automatic startTraining();
        tickNum = 0;
        for (int i = 0; i < NL; i++) pulseCnt[i] = 0;
        AlignStart = 1'b1;
        tick();
        AlignStart = 1'b0;
    endtask

    task automatic test_reset();
        DatRstN = 1'b0;
        FrmAlignDone = 1'b1;
        AlignStart = 1'b0;
        setAligned();
        repeat (3) tick();
        checks++; if (DatBitslip !== 4'b0) begin errors++; $display("FAIL reset_bitslip: got %b want 0000", DatBitslip); end
        checks++; if (DatData !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 00000000", DatData); end
        checks++; if (DatValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", DatValid); end
        checks++; if (DatAlignDone !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", DatAlignDone); end
        checks++; if (DatAlignErr !== 4'b0) begin errors++; $display("FAIL reset_err: got %b want 0000", DatAlignErr); end
        DatRstN = 1'b1;
        tickNum = 0;
        for (int i = 0; i < NL; i++) pulseCnt[i] = 0;
        repeat (4) tick();
        checks++; if (DatAlignDone !== 1'b0) begin errors++; $display("FAIL idle_done: got %b want 0", DatAlignDone); end
        checks++; if (pulseCnt[0] + pulseCnt[1] + pulseCnt[2] + pulseCnt[3] != 0) begin
            errors++; $display("FAIL idle_slips: got %0d want 0", pulseCnt[0] + pulseCnt[1] + pulseCnt[2] + pulseCnt[3]); end
        checks++; if (DatData !== 32'hEA55_EA55) begin errors++; $display("FAIL train_data: got %h want ea55ea55", DatData); end
    endtask

    task automatic test_lane0_slip();
        int doneTick;
        doneTick = 0;
        setAligned();
        offs[0] = 4;
        driveModel();
        startTraining();
        for (int t = 0; t < 39; t++) begin
            tick();
            if (DatAlignDone === 1'b1 && doneTick == 0) doneTick = tickNum;
        end
        checks++; if (pulseCnt[0] != 3) begin errors++; $display("FAIL slip_count: got %0d want 3", pulseCnt[0]); end
        checks++; if (pulseTick[0][0] != 2) begin errors++; $display("FAIL slip_first: got tick %0d want 2", pulseTick[0][0]); end
        checks++; if (pulseTick[0][1] != 8) begin errors++; $display("FAIL slip_second: got tick %0d want 8", pulseTick[0][1]); end
        checks++; if (pulseTick[0][2] != 14) begin errors++; $display("FAIL slip_third: got tick %0d want 14", pulseTick[0][2]); end
        checks++; if (pulseCnt[1] + pulseCnt[2] + pulseCnt[3] != 0) begin
            errors++; $display("FAIL slip_others: got %0d want 0", pulseCnt[1] + pulseCnt[2] + pulseCnt[3]); end
        checks++; if (doneTick != 24) begin errors++; $display("FAIL slip_done_tick: got %0d want 24", doneTick); end
        checks++; if (DatValid !== 1'b1) begin errors++; $display("FAIL slip_valid: got %b want 1", DatValid); end
        checks++; if (DatAlignErr !== 4'b0) begin errors++; $display("FAIL slip_err: got %b want 0000", DatAlignErr); end
    endtask

    task automatic test_lane_fail();
        int errTick;
        logic doneSeen;
        errTick = 0;
        doneSeen = 1'b0;
        setAligned();
        base[2] = 7'h00;
        driveModel();
        startTraining();
        checks++; if (DatAlignDone !== 1'b0) begin errors++; $display("FAIL restart_done_drop: got %b want 0", DatAlignDone); end
        for (int t = 0; t < 59; t++) begin
            tick();
            if (DatAlignDone === 1'b1) doneSeen = 1'b1;
            if (DatAlignErr[2] === 1'b1 && errTick == 0) errTick = tickNum;
        end
        checks++; if (pulseCnt[2] != 7) begin errors++; $display("FAIL fail_slips: got %0d want 7", pulseCnt[2]); end
        checks++; if (pulseTick[2][6] != 38) begin errors++; $display("FAIL fail_last_slip: got tick %0d want 38", pulseTick[2][6]); end
        checks++; if (errTick != 44) begin errors++; $display("FAIL fail_err_tick: got %0d want 44", errTick); end
        checks++; if (DatAlignErr !== 4'b0100) begin errors++; $display("FAIL fail_err: got %b want 0100", DatAlignErr); end
        checks++; if (doneSeen !== 1'b0) begin errors++; $display("FAIL fail_done: got %b want 0", doneSeen); end
        checks++; if (pulseCnt[0] + pulseCnt[1] + pulseCnt[3] != 0) begin
            errors++; $display("FAIL fail_others: got %0d want 0", pulseCnt[0] + pulseCnt[1] + pulseCnt[3]); end
    endtask

    task automatic test_live_data();
        setAligned();
        startTraining();
        checks++; if (DatAlignErr !== 4'b0) begin errors++; $display("FAIL relock_err_clear: got %b want 0000", DatAlignErr); end
        repeat (4) tick();
        checks++; if (DatAlignDone !== 1'b0) begin errors++; $display("FAIL relock_early: got %b want 0 at tick 5", DatAlignDone); end
        tick();
        checks++; if (DatAlignDone !== 1'b1) begin errors++; $display("FAIL relock_done: got %b want 1 at tick 6", DatAlignDone); end
        checks++; if (pulseCnt[0] + pulseCnt[1] + pulseCnt[2] + pulseCnt[3] != 0) begin
            errors++; $display("FAIL relock_slips: got %0d want 0", pulseCnt[0] + pulseCnt[1] + pulseCnt[2] + pulseCnt[3]); end

        modelOn = 1'b0;
        SerData = {toWire(7'h1F), toWire(7'h7F), toWire(7'h40), toWire(7'h01)};
        #1;
        checks++; if (DatData !== 32'hEA55_EA55) begin errors++; $display("FAIL live_latency: got %h want ea55ea55", DatData); end
        tick();
        checks++; if (DatData !== 32'h0FFF_E001) begin errors++; $display("FAIL live_a: got %h want 0fffe001", DatData); end
        checks++; if (DatValid !== 1'b1) begin errors++; $display("FAIL live_valid: got %b want 1", DatValid); end
        SerData = {toWire(7'h7F), toWire(7'h7F), toWire(7'h3F), toWire(7'h7F)};
        tick();
        checks++; if (DatData !== 32'hFFFF_1FFF) begin errors++; $display("FAIL live_b: got %h want ffff1fff", DatData); end
        SerData = {7'h00, 7'h00, 7'h00, 7'h01};
        tick();
`ifdef ADC_DATA_BITREV_EN
        checks++; if (DatData !== 32'h0000_0040) begin errors++; $display("FAIL live_order: got %h want 00000040", DatData); end
`else
        checks++; if (DatData !== 32'h0000_0001) begin errors++; $display("FAIL live_order: got %h want 00000001", DatData); end
`endif
        checks++; if (DatAlignDone !== 1'b1) begin errors++; $display("FAIL live_hold_lock: got %b want 1", DatAlignDone); end
    endtask

    task automatic test_frm_drop();
        int doneTick;
        doneTick = 0;
        setAligned();
        FrmAlignDone = 1'b0;
        tick();
        checks++; if (DatAlignDone !== 1'b0) begin errors++; $display("FAIL frm_done_drop: got %b want 0", DatAlignDone); end
        checks++; if (DatValid !== 1'b0) begin errors++; $display("FAIL frm_valid_drop: got %b want 0", DatValid); end
        FrmAlignDone = 1'b1;
        repeat (6) tick();
        checks++; if (DatAlignDone !== 1'b0) begin errors++; $display("FAIL frm_idle: got %b want 0", DatAlignDone); end

        offs[0] = 4;
        driveModel();
        startTraining();
        tick();
        checks++; if (DatBitslip !== 4'b0001) begin errors++; $display("FAIL frm_pulse: got %b want 0001", DatBitslip); end
        repeat (2) tick();
        FrmAlignDone = 1'b0;
        repeat (20) tick();
        checks++; if (pulseCnt[0] != 1) begin errors++; $display("FAIL frm_no_slip: got %0d want 1", pulseCnt[0]); end
        checks++; if (DatAlignDone !== 1'b0) begin errors++; $display("FAIL frm_low_done: got %b want 0", DatAlignDone); end

        FrmAlignDone = 1'b1;
        startTraining();
        for (int t = 0; t < 29; t++) begin
            tick();
            if (DatAlignDone === 1'b1 && doneTick == 0) doneTick = tickNum;
        end
        checks++; if (pulseCnt[0] != 2) begin errors++; $display("FAIL frm_relock_slips: got %0d want 2", pulseCnt[0]); end
        checks++; if (doneTick != 18) begin errors++; $display("FAIL frm_relock_tick: got %0d want 18", doneTick); end
    endtask

    task automatic test_async_reset();
        setAligned();
        offs[0] = 3;
        driveModel();
        startTraining();
        tick();
        checks++; if (DatBitslip !== 4'b0001) begin errors++; $display("FAIL rst_pulse_pre: got %b want 0001", DatBitslip); end
        #2;
        DatRstN = 1'b0;
        #1;
        checks++; if (DatBitslip !== 4'b0) begin errors++; $display("FAIL rst_async_bitslip: got %b want 0000", DatBitslip); end
        checks++; if (DatData !== 32'h0) begin errors++; $display("FAIL rst_async_data: got %h want 00000000", DatData); end
        checks++; if ({DatValid, DatAlignDone} !== 2'b00) begin errors++; $display("FAIL rst_async_flags: got %b want 00", {DatValid, DatAlignDone}); end
        checks++; if (DatAlignErr !== 4'b0) begin errors++; $display("FAIL rst_async_err: got %b want 0000", DatAlignErr); end
        tick();
        DatRstN = 1'b1;
        repeat (10) tick();
        checks++; if (pulseCnt[0] != 1) begin errors++; $display("FAIL rst_no_resume: got %0d want 1", pulseCnt[0]); end
        checks++; if (DatAlignDone !== 1'b0) begin errors++; $display("FAIL rst_idle_done: got %b want 0", DatAlignDone); end
    endtask

    initial begin
        test_reset();
        test_lane0_slip();
        test_lane_fail();
        test_live_data();
        test_frm_drop();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time %0t exceeded limit 200000", $time);
        $fatal(1, "watchdog");
    end

endmodule
